// File: rtl/vector_checker_pkg.sv
// Shared types and entry-layout helpers for the vector checker.
// An entry is packed as {end, stim[NIN-1:0], exp[NOUT-1:0]}.
package vector_checker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int expLsb(input int nin, input int nout);
    return 0;
  endfunction

  function automatic int stimLsb(input int nin, input int nout);
    return nout;
  endfunction

  function automatic int endBit(input int nin, input int nout);
    return nin + nout;
  endfunction

  function automatic int entryWidth(input int nin, input int nout);
    return nin + nout + 1;
  endfunction

endpackage

// File: rtl/vector_checker_if.sv
// Host/DUT-facing bundle of the vector checker: table load, run control,
// stimulus/response pair and result reporting.
interface vector_checker_if
  import vector_checker_pkg::*;
#(
  parameter int NIN   = 2,
  parameter int NOUT  = 1,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = entryWidth(NIN, NOUT);

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [EW-1:0] wr_data;
  logic          start;
  logic          stop_on_err;
  logic [NIN-1:0]  dut_in;
  logic [NOUT-1:0] dut_out;
  logic          busy;
  logic          done;
  logic          pass;
  logic [AW:0]   err_count;
  logic [AW:0]   num_tested;
  logic          err_valid;
  logic [AW-1:0] err_index;
  logic [NOUT-1:0] err_exp;
  logic [NOUT-1:0] err_act;

  modport master (
    output wr_en, wr_addr, wr_data, start, stop_on_err, dut_out,
    input  dut_in, busy, done, pass, err_count, num_tested,
           err_valid, err_index, err_exp, err_act
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, stop_on_err, dut_out,
    output dut_in, busy, done, pass, err_count, num_tested,
           err_valid, err_index, err_exp, err_act
  );

endinterface

// File: rtl/vector_checker_mem.sv
// Vector table: register array with one synchronous write port and one
// asynchronous read port; only the terminator bits are reset.
module vector_mem
  import vector_checker_pkg::*;
#(
  parameter int NIN   = 2,
  parameter int NOUT  = 1,
  parameter int DEPTH = 16
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              we_i,
  input  logic [$clog2(DEPTH)-1:0]          waddr_i,
  input  logic [entryWidth(NIN, NOUT)-1:0]  wdata_i,
  input  logic [$clog2(DEPTH)-1:0]          raddr_i,
  output logic                              rterm_o,
  output logic [NIN-1:0]                    rstim_o,
  output logic [NOUT-1:0]                   rexp_o
);

  localparam int EXP_LSB  = expLsb(NIN, NOUT);
  localparam int STIM_LSB = stimLsb(NIN, NOUT);
  localparam int END_BIT  = endBit(NIN, NOUT);

  logic [DEPTH-1:0] term_q;
  logic [NIN-1:0]   stim_q [DEPTH];
  logic [NOUT-1:0]  exp_q  [DEPTH];

  // A freshly reset table reads as empty: every slot is a terminator.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      term_q <= '1;
    end else if (we_i) begin
      term_q[waddr_i] <= wdata_i[END_BIT];
    end
  end

  always_ff @(posedge clk) begin
    if (we_i) begin
      stim_q[waddr_i] <= wdata_i[STIM_LSB +: NIN];
      exp_q[waddr_i]  <= wdata_i[EXP_LSB +: NOUT];
    end
  end

  assign rterm_o = term_q[raddr_i];
  assign rstim_o = stim_q[raddr_i];
  assign rexp_o  = exp_q[raddr_i];

endmodule

// File: rtl/vector_checker.sv
// Hardware vector sequencer: applies table stimuli to a cell under test,
// waits SETTLE cycles, compares the response and accumulates mismatches.
module vector_checker
  import vector_checker_pkg::*;
#(
  parameter int NIN    = 2,
  parameter int NOUT   = 1,
  parameter int DEPTH  = 16,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  vector_checker_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t          state_q;
  logic [AW-1:0]   index_q;
  logic [SW-1:0]   settle_q;
  logic [NOUT-1:0] exp_q;
  logic            stop_q;
  logic [NIN-1:0]  dutIn_q;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;
  logic [AW:0]     errCount_q;
  logic [AW:0]     numTested_q;
  logic            errValid_q;
  logic [AW-1:0]   errIndex_q;
  logic [NOUT-1:0] errExp_q;
  logic [NOUT-1:0] errAct_q;

  logic [AW-1:0]   readAddr;
  logic [AW-1:0]   nextIndex;
  logic            rdTerm;
  logic [NIN-1:0]  rdStim;
  logic [NOUT-1:0] rdExp;
  logic            mismatch;
  logic            lastIndex;
  logic [AW:0]     errCount_d;

  vector_mem #(
    .NIN   (NIN),
    .NOUT  (NOUT),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .we_i    (bus.wr_en && !busy_q),
    .waddr_i (bus.wr_addr),
    .wdata_i (bus.wr_data),
    .raddr_i (readAddr),
    .rterm_o (rdTerm),
    .rstim_o (rdStim),
    .rexp_o  (rdExp)
  );

  // The read port looks ahead to the entry about to be applied, so the
  // stimulus can be registered on the same edge that enters APPLY.
  always_comb begin
    nextIndex = index_q + 1'b1;
    case (state_q)
      APPLY:   readAddr = index_q;
      CHECK:   readAddr = nextIndex;
      default: readAddr = '0;
    endcase
    mismatch   = (bus.dut_out !== exp_q);
    lastIndex  = (index_q == AW'(DEPTH - 1));
    errCount_d = errCount_q + ((mismatch) ? (AW+1)'(1) : (AW+1)'(0));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      index_q     <= '0;
      settle_q    <= '0;
      exp_q       <= '0;
      stop_q      <= 1'b0;
      dutIn_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      errCount_q  <= '0;
      numTested_q <= '0;
      errValid_q  <= 1'b0;
      errIndex_q  <= '0;
      errExp_q    <= '0;
      errAct_q    <= '0;
    end else begin
      errValid_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_q     <= APPLY;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            errCount_q  <= '0;
            numTested_q <= '0;
            index_q     <= '0;
            settle_q    <= '0;
            stop_q      <= bus.stop_on_err;
            errIndex_q  <= '0;
            errExp_q    <= '0;
            errAct_q    <= '0;
            if (!rdTerm) begin
              dutIn_q <= rdStim;
              exp_q   <= rdExp;
            end
          end
        end
        APPLY: begin
          if (settle_q == '0 && rdTerm) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (errCount_q == '0);
          end else if (settle_q == SW'(SETTLE - 1)) begin
            state_q <= CHECK;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        CHECK: begin
          numTested_q <= numTested_q + 1'b1;
          if (mismatch) begin
            errCount_q <= errCount_d;
            errValid_q <= 1'b1;
            errIndex_q <= index_q;
            errExp_q   <= exp_q;
            errAct_q   <= bus.dut_out;
          end
          if ((mismatch && stop_q) || lastIndex) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (errCount_d == '0);
          end else begin
            state_q  <= APPLY;
            index_q  <= nextIndex;
            settle_q <= '0;
            if (!rdTerm) begin
              dutIn_q <= rdStim;
              exp_q   <= rdExp;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.dut_in     = dutIn_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_count  = errCount_q;
  assign bus.num_tested = numTested_q;
  assign bus.err_valid  = errValid_q;
  assign bus.err_index  = errIndex_q;
  assign bus.err_exp    = errExp_q;
  assign bus.err_act    = errAct_q;

endmodule

// File: tb/tb_vector_checker.sv
// Directed bench: two checkers (DEPTH=16/SETTLE=1 and DEPTH=4/SETTLE=3)
// each sequencing a behavioural nand2 with a 1-unit propagation delay.
module tb_vector_checker;

  logic clk;
  logic reset_n;
  int   compared;
  int   mismatched;
  int   pulsesA;

  vector_checker_if #(.NIN(2), .NOUT(1), .DEPTH(16)) bA ();
  vector_checker_if #(.NIN(2), .NOUT(1), .DEPTH(4))  bB ();

  vector_checker #(.NIN(2), .NOUT(1), .DEPTH(16), .SETTLE(1)) uA (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bA.slave)
  );

  vector_checker #(.NIN(2), .NOUT(1), .DEPTH(4), .SETTLE(3)) uB (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bB.slave)
  );

  assign #1 bA.dut_out = ~&bA.dut_in;
  assign #1 bB.dut_out = ~&bB.dut_in;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bA.err_valid === 1'b1) pulsesA++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic writeA(input int addr, input logic [3:0] data);
    @(negedge clk);
    bA.wr_en   = 1'b1;
    bA.wr_addr = 4'(addr);
    bA.wr_data = data;
    @(posedge clk);
    #1 bA.wr_en = 1'b0;
  endtask

  task automatic writeB(input int addr, input logic [3:0] data);
    @(negedge clk);
    bB.wr_en   = 1'b1;
    bB.wr_addr = 2'(addr);
    bB.wr_data = data;
    @(posedge clk);
    #1 bB.wr_en = 1'b0;
  endtask

  // Returns at the falling edge following the start edge (edge 0).
  task automatic applyStimulus(input logic stopErr);
    @(negedge clk);
    pulsesA        = 0;
    bA.stop_on_err = stopErr;
    bA.start       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bA.start = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    pulsesA    = 0;
    reset_n    = 1'b0;
    bA.wr_en = 1'b0; bA.wr_addr = '0; bA.wr_data = '0; bA.start = 1'b0; bA.stop_on_err = 1'b0;
    bB.wr_en = 1'b0; bB.wr_addr = '0; bB.wr_data = '0; bB.start = 1'b0; bB.stop_on_err = 1'b0;

    #2;
    checkOutput("rst_busy", 32'(bA.busy), 0);
    checkOutput("rst_done", 32'(bA.done), 0);
    checkOutput("rst_pass", 32'(bA.pass), 0);
    checkOutput("rst_errcnt", 32'(bA.err_count), 0);
    checkOutput("rst_tested", 32'(bA.num_tested), 0);
    checkOutput("rst_dutin", 32'(bA.dut_in), 0);
    checkOutput("rst_errvalid", 32'(bA.err_valid), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Good nand2 table with terminator at 4
    writeA(0, 4'b0_00_1);
    writeA(1, 4'b0_01_1);
    writeA(2, 4'b0_10_1);
    writeA(3, 4'b0_11_0);
    writeA(4, 4'b1_00_0);
    applyStimulus(1'b0);
    checkOutput("good_busy_e0", 32'(bA.busy), 1);
    checkOutput("good_done_e0", 32'(bA.done), 0);
    repeat (8) @(negedge clk);
    checkOutput("good_done_e8", 32'(bA.done), 0);
    @(negedge clk);
    checkOutput("good_done_e9", 32'(bA.done), 1);
    checkOutput("good_busy_e9", 32'(bA.busy), 0);
    checkOutput("good_pass", 32'(bA.pass), 1);
    checkOutput("good_tested", 32'(bA.num_tested), 4);
    checkOutput("good_errcnt", 32'(bA.err_count), 0);
    checkOutput("good_dutin_hold", 32'(bA.dut_in), 3);
    checkOutput("good_no_pulse", 32'(pulsesA), 0);

    // Entry 3 expects 1 but nand(1,1)=0
    writeA(3, 4'b0_11_1);
    applyStimulus(1'b0);
    repeat (8) @(negedge clk);
    checkOutput("bad3_errvalid", 32'(bA.err_valid), 1);
    checkOutput("bad3_errcnt_e8", 32'(bA.err_count), 1);
    checkOutput("bad3_index", 32'(bA.err_index), 3);
    checkOutput("bad3_exp", 32'(bA.err_exp), 1);
    checkOutput("bad3_act", 32'(bA.err_act), 0);
    @(negedge clk);
    checkOutput("bad3_errvalid_off", 32'(bA.err_valid), 0);
    checkOutput("bad3_done", 32'(bA.done), 1);
    checkOutput("bad3_pass", 32'(bA.pass), 0);
    checkOutput("bad3_errcnt", 32'(bA.err_count), 1);
    checkOutput("bad3_tested", 32'(bA.num_tested), 4);
    checkOutput("bad3_pulses", 32'(pulsesA), 1);

    // Entry 1 also wrong, halt at first mismatch
    writeA(1, 4'b0_01_0);
    applyStimulus(1'b1);
    repeat (3) @(negedge clk);
    checkOutput("stop_done_e3", 32'(bA.done), 0);
    @(negedge clk);
    checkOutput("stop_done_e4", 32'(bA.done), 1);
    checkOutput("stop_busy", 32'(bA.busy), 0);
    checkOutput("stop_tested", 32'(bA.num_tested), 2);
    checkOutput("stop_errcnt", 32'(bA.err_count), 1);
    checkOutput("stop_index", 32'(bA.err_index), 1);
    checkOutput("stop_exp", 32'(bA.err_exp), 0);
    checkOutput("stop_act", 32'(bA.err_act), 1);
    checkOutput("stop_pass", 32'(bA.pass), 0);

    // start and write pulsed while busy must both be ignored
    applyStimulus(1'b0);
    repeat (2) @(negedge clk);
    bA.wr_en   = 1'b1;
    bA.wr_addr = 4'd0;
    bA.wr_data = 4'b1_00_0;
    bA.start   = 1'b1;
    @(negedge clk);
    bA.wr_en = 1'b0;
    bA.start = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("busyign_done_e8", 32'(bA.done), 0);
    @(negedge clk);
    checkOutput("busyign_done_e9", 32'(bA.done), 1);
    checkOutput("busyign_tested", 32'(bA.num_tested), 4);
    checkOutput("busyign_errcnt", 32'(bA.err_count), 2);

    // Reset while vector 2 is being applied
    applyStimulus(1'b0);
    repeat (4) @(negedge clk);
    checkOutput("midrst_busy_pre", 32'(bA.busy), 1);
    checkOutput("midrst_errcnt_pre", 32'(bA.err_count), 1);
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(bA.busy), 0);
    checkOutput("midrst_errcnt", 32'(bA.err_count), 0);
    checkOutput("midrst_tested", 32'(bA.num_tested), 0);
    checkOutput("midrst_dutin", 32'(bA.dut_in), 0);
    checkOutput("midrst_index", 32'(bA.err_index), 0);
    checkOutput("midrst_act", 32'(bA.err_act), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Table is empty again after reset
    applyStimulus(1'b0);
    checkOutput("empty_busy_e0", 32'(bA.busy), 1);
    @(negedge clk);
    checkOutput("empty_done_e1", 32'(bA.done), 1);
    checkOutput("empty_tested", 32'(bA.num_tested), 0);
    checkOutput("empty_pass", 32'(bA.pass), 1);
    checkOutput("empty_dutin", 32'(bA.dut_in), 0);

    // Reloaded good table completes normally
    writeA(0, 4'b0_00_1);
    writeA(1, 4'b0_01_1);
    writeA(2, 4'b0_10_1);
    writeA(3, 4'b0_11_0);
    applyStimulus(1'b0);
    repeat (9) @(negedge clk);
    checkOutput("reload_done", 32'(bA.done), 1);
    checkOutput("reload_pass", 32'(bA.pass), 1);
    checkOutput("reload_tested", 32'(bA.num_tested), 4);

    // Full DEPTH=4 table, no terminator, SETTLE=3, last entry wrong
    writeB(0, 4'b0_00_1);
    writeB(1, 4'b0_01_1);
    writeB(2, 4'b0_10_1);
    writeB(3, 4'b0_11_1);
    @(negedge clk);
    bB.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bB.start = 1'b0;
    checkOutput("full_busy_e0", 32'(bB.busy), 1);
    repeat (15) @(negedge clk);
    checkOutput("full_done_e15", 32'(bB.done), 0);
    checkOutput("full_errvalid_e15", 32'(bB.err_valid), 0);
    @(negedge clk);
    checkOutput("full_done_e16", 32'(bB.done), 1);
    checkOutput("full_busy_e16", 32'(bB.busy), 0);
    checkOutput("full_tested", 32'(bB.num_tested), 4);
    checkOutput("full_errcnt", 32'(bB.err_count), 1);
    checkOutput("full_errvalid", 32'(bB.err_valid), 1);
    checkOutput("full_index", 32'(bB.err_index), 3);
    checkOutput("full_pass", 32'(bB.pass), 0);
    checkOutput("full_dutin", 32'(bB.dut_in), 3);
    repeat (3) @(negedge clk);
    checkOutput("full_no_wrap", 32'(bB.num_tested), 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/vector_checker.md
# vector_checker

Synthesisable, parametrised self-checking vector engine for small combinational cells (nand2 and wider successors). It holds a loaded table of stimulus/expected-response entries, drives each stimulus onto a DUT, waits a programmable settle time, compares the DUT response and counts mismatches. It sits beside a cell under test, in simulation or on an FPGA bring-up harness, and replaces file-driven bench loops with hardware sequencing.

## Interface
Parameters:
- NIN, 2: DUT input width.
- NOUT, 1: DUT output width.
- DEPTH, 16: vector table entries, power of two, at least 2.
- SETTLE, 1: cycles stimulus is held before compare, at least 1.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  table write strobe; ignored while busy.
- wr_addr  in  AW=$clog2(DEPTH)  table write address.
- wr_data  in  NIN+NOUT+1  entry: {end, stim[NIN-1:0], exp[NOUT-1:0]}.
- start  in  1  begin a run; ignored while busy.
- stop_on_err  in  1  sampled at start; halts the run at the first mismatch.
- dut_in  out  NIN  stimulus to the DUT.
- dut_out  in  NOUT  DUT response.
- busy  out  1  run in progress.
- done  out  1  run finished; held until next start.
- pass  out  1  valid when done: err_count==0.
- err_count  out  AW+1  mismatches this run.
- num_tested  out  AW+1  vectors compared this run.
- err_valid  out  1  one-cycle pulse on mismatch.
- err_index, err_exp, err_act  out  AW / NOUT / NOUT  mismatch details, held until next mismatch or start.

## Operation
- Table: DEPTH entries. On reset, every end bit is set to 1; stim/exp are not reset. Write is one cycle, when wr_en && !busy.
- An entry with end=1 is a terminator. It is never applied or compared.
- FSM states: IDLE, APPLY, CHECK, DONE.
  - IDLE/DONE + start: clear err_count, num_tested, index and done; latch stop_on_err; go to APPLY.
  - APPLY, first cycle: if entry[index].end, go to DONE. Otherwise drive dut_in=stim and hold it for SETTLE cycles, then go to CHECK.
  - CHECK, one cycle: compare dut_out against exp with !==, so X/Z counts as a mismatch. num_tested increments.
    - On mismatch: err_count increments, err_valid pulses, and details are latched.
    - Go to DONE if (mismatch && stop_on_err) or index==DEPTH-1. Otherwise increment index and go to APPLY.
- Index never wraps. A full table with no terminator ends after DEPTH compares.
- dut_in holds the last stimulus in DONE and IDLE.
- Counters are AW+1 bits wide and cannot overflow (maximum DEPTH).
- start while busy is ignored, and so is wr_en while busy.
- start and wr_en in the same idle cycle: the write lands, but the run reads the old entry 0 contents only if index 0 was written. Benches must not rely on this.
- Reset mid-run: immediate return to IDLE, all outputs go to reset values and the table end bits are set again.

## Timing
- Reset values: dut_in=0, busy=0, done=0, pass=0, err_count=0, num_tested=0, err_valid=0, err_index=0, err_exp=0, err_act=0; FSM in IDLE.
- Start accepted on edge 0. busy=1 from edge 0 and APPLY from edge 0.
- Each vector costs SETTLE+1 cycles. The compare happens in the cycle after the last settle cycle, so dut_out has SETTLE full cycles to settle.
- A terminator costs 1 cycle. For N vectors plus a terminator, done=1 and busy=0 from edge N*(SETTLE+1)+1.
- err_valid is asserted the cycle after the CHECK edge, together with the updated err_count.

## Structure
- Package vector_checker_pkg: state_t enum {IDLE, APPLY, CHECK, DONE} and entry field-offset localparams as functions of NIN/NOUT.
- Sub-module vector_mem: DEPTH-entry register array with a synchronous write port, asynchronous read and asynchronously reset end bits.
- Top level contains the FSM, settle counter, index and counters, roughly 200 lines in total.

## Test plan
- NAND2 (NIN=2, NOUT=1, SETTLE=1), behavioural nand2 with #1 delay, table {0,00,1},{0,01,1},{0,10,1},{0,11,0},{1,..}: expect done at edge 9, pass=1, num_tested=4, err_count=0, no err_valid.
- Same table with entry 3 exp=1: err_valid pulses once with err_index=3, err_exp=1, err_act=0; final err_count=1, pass=0.
- Same faulty table with entry 1 also wrong and stop_on_err=1: run halts after index 1 with num_tested=2, err_count=1, done=1.
- No terminator, DEPTH=4, SETTLE=3: done after exactly 4*4 cycles, num_tested=4, and index does not wrap.
- Empty table straight after reset, then start: done at edge 1, num_tested=0, pass=1.
- reset_n low mid-run at vector 2: all outputs return to 0 immediately. A following start with a reloaded table completes normally. wr_en and start pulsed while busy have no effect.
